// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB register: issues loads/stores over a req/ack port, stalls
// the pipe while waiting, and drives the register-file write port.
module mem_wb_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_wreg,
  input  logic [4:0]  ex_wd,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_store_data,
  input  logic        flush,
  output logic        stall_req,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        w_en,
  output logic [4:0]  w_addr,
  output logic [31:0] w_data,
  output logic        exc_misalign,
  output logic        bus_err
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic {IDLE, ACCESS} state_t;

  function automatic logic is_mem(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return |a;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'b0001 << a;
      OP_LH, OP_LHU, OP_SH: return a[1] ? 4'b1100 : 4'b0011;
      default:              return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [3:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   return {4{d[7:0]}};
      OP_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Pick the addressed lane and sign/zero-extend it to a full register.
  function automatic logic [31:0] load_lane(input logic [3:0] op, input logic [1:0] a,
                                            input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'd0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'd0, h};
      default: return d;
    endcase
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_p1;
  logic [4:0]       wd_p1;
  logic             wreg_p1;
  logic [1:0]       a_p1;

  logic ex_live, ex_mem, ex_mis, issue, timeout, done;

  assign ex_live = ex_valid && !flush;
  assign ex_mem  = ex_live && is_mem(ex_mem_op);
  assign ex_mis  = ex_mem && misaligned(ex_mem_op, ex_mem_addr[1:0]);
  assign issue   = ex_mem && !ex_mis;
  assign timeout = TO_EN && (cnt == TO_VAL) && !dm_ack;
  assign done    = dm_ack || timeout;

  always_comb begin
    state_nxt = state;
    stall_req = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          stall_req = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        stall_req = !dm_ack;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage boundary: EX -> MEM/WB register and memory request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= '0;
      dm_be        <= '0;
      dm_wdata     <= '0;
      w_en         <= 1'b0;
      w_addr       <= '0;
      w_data       <= '0;
      exc_misalign <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      w_en         <= 1'b0;
      exc_misalign <= 1'b0;
      bus_err      <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        if (issue) begin
          // Counter holds the 1-based index of the current ACCESS cycle.
          cnt      <= CNT_W'(1);
          dm_req   <= 1'b1;
          dm_we    <= is_store(ex_mem_op);
          dm_addr  <= {ex_mem_addr[31:2], 2'b00};
          dm_be    <= byte_en(ex_mem_op, ex_mem_addr[1:0]);
          dm_wdata <= lane_wdata(ex_mem_op, ex_store_data);
        end else if (ex_mis) begin
          exc_misalign <= 1'b1;
        end else if (ex_live && !ex_mem) begin
          w_en   <= ex_wreg;
          w_addr <= ex_wd;
          w_data <= ex_wdata;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (done) begin
          cnt    <= '0;
          dm_req <= 1'b0;
        end
        if (dm_ack) begin
          if (!is_store(op_p1)) begin
            w_en   <= wreg_p1;
            w_addr <= wd_p1;
            w_data <= load_lane(op_p1, a_p1, dm_rdata);
          end
        end else if (timeout) begin
          bus_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && issue) begin
      op_p1   <= ex_mem_op;
      wd_p1   <= ex_wd;
      wreg_p1 <= ex_wreg;
      a_p1    <= ex_mem_addr[1:0];
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: write-back scoreboard plus directed checks
// of the memory port, stall, misalign, timeout, flush and reset behaviour.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_wreg, flush;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata, ex_mem_addr, ex_store_data;
  logic [3:0]  ex_mem_op;
  logic        stall_req, dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        exc_misalign, bus_err;

  mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .flush(flush), .stall_req(stall_req),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .exc_misalign(exc_misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wb_t;

  wb_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  n_mis = 0;
  int  n_berr = 0;
  int  n_stall = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write-back monitor: every w_en pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst) begin
      if (exc_misalign) n_mis++;
      if (bus_err) n_berr++;
      if (stall_req) n_stall++;
      if (w_en) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 32'd1, 32'd0);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          chk("wb_addr", {27'd0, w_addr}, {27'd0, e.a});
          chk("wb_data", w_data, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_wreg = 1'b0; ex_wd = '0; ex_wdata = '0;
    ex_mem_op = '0; ex_mem_addr = '0; ex_store_data = '0; flush = 1'b0;
  endtask

  task automatic alu(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                     input logic [31:0] wdata);
    ex_valid = 1'b1; ex_mem_op = op; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    if (wreg) exp_q.push_back({wd, wdata});
    @(negedge clk);
    chk("alu_nostall", {31'd0, stall_req}, 32'd0);
    tick();
    idle_ex();
  endtask

  // Aligned memory op acked after wait_n non-ack ACCESS cycles.
  task automatic mem_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [4:0] wd, input int wait_n,
                        input logic [31:0] rdata, input logic [3:0] xbe,
                        input logic [31:0] xwdata, input logic [31:0] xload);
    logic st;
    st = (op >= 4'd6);
    ex_valid = 1'b1; ex_mem_op = op; ex_mem_addr = addr; ex_store_data = sd;
    ex_wd = wd; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF;
    n_stall = 0;
    @(negedge clk);
    chk({tag, "_issue_stall"}, {31'd0, stall_req}, 32'd1);
    chk({tag, "_req_pre"}, {31'd0, dm_req}, 32'd0);
    tick();
    chk({tag, "_req"}, {31'd0, dm_req}, 32'd1);
    chk({tag, "_we"}, {31'd0, dm_we}, {31'd0, st});
    chk({tag, "_addr"}, dm_addr, {addr[31:2], 2'b00});
    chk({tag, "_be"}, {28'd0, dm_be}, {28'd0, xbe});
    if (st) chk({tag, "_wdata"}, dm_wdata, xwdata);
    repeat (wait_n) tick();
    dm_ack = 1'b1; dm_rdata = rdata;
    if (!st) exp_q.push_back({wd, xload});
    @(negedge clk);
    chk({tag, "_ack_stall"}, {31'd0, stall_req}, 32'd0);
    tick();
    dm_ack = 1'b0; dm_rdata = 32'h5A5A_5A5A;
    idle_ex();
    chk({tag, "_req_drop"}, {31'd0, dm_req}, 32'd0);
    chk({tag, "_stall_cycles"}, n_stall, 1 + wait_n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_ex();
    dm_ack = 1'b0; dm_rdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("rst_w_en", {31'd0, w_en}, 32'd0);
    chk("rst_outs", {dm_addr | dm_wdata | w_data}, 32'd0);
    chk("rst_flags", {26'd0, dm_we, dm_be, exc_misalign | bus_err}, 32'd0);
    chk("rst_w_addr", {27'd0, w_addr}, 32'd0);
    rst = 1'b0;
    tick();

    alu(4'd0, 5'd3, 1'b1, 32'h0000_1234);
    alu(4'd0, 5'd7, 1'b0, 32'h1111_1111);
    alu(4'd12, 5'd0, 1'b1, 32'hCAFE_F00D);
    tick();

    mem_op("lb",  4'd1, 32'h103, 32'h0, 5'd4, 3, 32'h80FF_FFFF, 4'b1000, 32'h0, 32'hFFFF_FF80);
    mem_op("lbu", 4'd2, 32'h103, 32'h0, 5'd5, 3, 32'h80FF_FFFF, 4'b1000, 32'h0, 32'h0000_0080);
    mem_op("lh",  4'd3, 32'h102, 32'h0, 5'd6, 1, 32'h8001_7777, 4'b1100, 32'h0, 32'hFFFF_8001);
    mem_op("lhu", 4'd4, 32'h100, 32'h0, 5'd8, 0, 32'h1234_F00D, 4'b0011, 32'h0, 32'h0000_F00D);
    mem_op("sh",  4'd7, 32'h202, 32'hABCD_1234, 5'd9, 0, 32'h0, 4'b1100, 32'h1234_1234, 32'h0);
    mem_op("sb",  4'd6, 32'h301, 32'h0000_00AB, 5'd9, 2, 32'h0, 4'b0010, 32'hABAB_ABAB, 32'h0);
    mem_op("sw",  4'd8, 32'h400, 32'h9876_5432, 5'd9, 0, 32'h0, 4'b1111, 32'h9876_5432, 32'h0);
    mem_op("lw4", 4'd5, 32'h500, 32'h0, 5'd10, 3, 32'h0BAD_CAFE, 4'b1111, 32'h0, 32'h0BAD_CAFE);
    chk("no_bus_err_on_late_ack", n_berr, 0);

    // Misaligned word load
    ex_valid = 1'b1; ex_mem_op = 4'd5; ex_mem_addr = 32'h101; ex_wd = 5'd11; ex_wreg = 1'b1;
    @(negedge clk);
    chk("mis_nostall", {31'd0, stall_req}, 32'd0);
    tick();
    idle_ex();
    chk("mis_pulse", {31'd0, exc_misalign}, 32'd1);
    chk("mis_noreq", {31'd0, dm_req}, 32'd0);
    tick();
    chk("mis_pulse_end", {31'd0, exc_misalign}, 32'd0);
    chk("mis_count", n_mis, 1);

    // Timeout: LW never acked
    ex_valid = 1'b1; ex_mem_op = 4'd5; ex_mem_addr = 32'h600; ex_wd = 5'd12; ex_wreg = 1'b1;
    tick();
    idle_ex();
    repeat (3) tick();
    @(negedge clk);
    chk("to_stall_c4", {31'd0, stall_req}, 32'd1);
    chk("to_no_berr_yet", {31'd0, bus_err}, 32'd0);
    tick();
    chk("to_berr", {31'd0, bus_err}, 32'd1);
    chk("to_req_drop", {31'd0, dm_req}, 32'd0);
    chk("to_stall_rel", {31'd0, stall_req}, 32'd0);
    tick();
    chk("to_berr_end", {31'd0, bus_err}, 32'd0);
    chk("to_count", n_berr, 1);

    // Flush of an aligned load in IDLE
    ex_valid = 1'b1; flush = 1'b1; ex_mem_op = 4'd5; ex_mem_addr = 32'h700; ex_wd = 5'd13;
    ex_wreg = 1'b1;
    @(negedge clk);
    chk("flush_nostall", {31'd0, stall_req}, 32'd0);
    tick();
    idle_ex();
    chk("flush_noreq", {31'd0, dm_req}, 32'd0);
    chk("flush_no_wen", {31'd0, w_en}, 32'd0);
    tick();

    // Reset asserted mid-ACCESS
    ex_valid = 1'b1; ex_mem_op = 4'd5; ex_mem_addr = 32'h800; ex_wd = 5'd14; ex_wreg = 1'b1;
    tick();
    idle_ex();
    chk("rstacc_req_before", {31'd0, dm_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstacc_req", {31'd0, dm_req}, 32'd0);
    chk("rstacc_w_en", {31'd0, w_en}, 32'd0);
    dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    tick();
    dm_ack = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    chk("rstacc_idle", {30'd0, dm_req, stall_req}, 32'd0);

    alu(4'd0, 5'd0, 1'b1, 32'h0000_00FF);
    tick();
    tick();
    chk("sb_drain", exp_q.size(), 0);
    chk("mis_total", n_mis, 1);
    chk("berr_total", n_berr, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
